// File: rtl/btn_press_decoder.sv
// ---------------------------------------------------------------------------
// btn_press_decoder
//
// Classifies presses of a debounced, clk-synchronous button level as short,
// long or double-click. Each classified gesture produces exactly one
// registered single-cycle pulse.
//
// Parameters:
//   LONG_CNT   - high samples after the rise that make a press long (>= 2)
//   DOUBLE_GAP - low samples after a release inside which a new rise is a
//                double-click (>= 1); unused when BTN_DOUBLE_EN is undefined
//
// Ports:
//   clk          - system clock, all logic on posedge
//   reset        - asynchronous, active-high; clears all state
//   btn_stable   - debounced button level, 1 = pressed
//   short_press  - one-cycle pulse, short press classified
//   long_press   - one-cycle pulse, long press classified
//   double_click - one-cycle pulse, double-click classified
//   busy         - high whenever the classifier is not idle
//
// Build option:
//   BTN_DOUBLE_EN - when defined, builds the inter-press gap state and the
//                   double_click output. When undefined, a release in PRESS1
//                   is classified short immediately and double_click is 0.
// ---------------------------------------------------------------------------
module btn_press_decoder #(
    parameter int unsigned LONG_CNT   = 20,
    parameter int unsigned DOUBLE_GAP = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_stable,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic busy
);

    if (LONG_CNT < 2 || DOUBLE_GAP < 1) begin : g_bad_params
        $error("btn_press_decoder: LONG_CNT must be >= 2 and DOUBLE_GAP >= 1");
    end

`ifdef BTN_DOUBLE_EN
    localparam int unsigned CNT_MAX = (LONG_CNT > DOUBLE_GAP) ? LONG_CNT : DOUBLE_GAP;
`else
    localparam int unsigned CNT_MAX = LONG_CNT;
`endif
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

    // cnt is cleared on entry to each state, so the sample that makes the
    // count reach N is the one seen while cnt still holds N-1.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);

`ifdef BTN_DOUBLE_EN
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(DOUBLE_GAP - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS1   = 2'd1,
        WAIT_REL = 2'd2,
        GAP      = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS1   = 2'd1,
        WAIT_REL = 2'd2
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_dly_q, btn_dly_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             dbl_q, dbl_d;

    logic rise;
    logic fall;

    assign rise = btn_stable & ~btn_dly_q;
    assign fall = ~btn_stable & btn_dly_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        btn_dly_d = btn_stable;
        short_d   = 1'b0;
        long_d    = 1'b0;
        dbl_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESS1;
                end
            end
            PRESS1: begin
                // A fall takes priority: the long condition needs a high sample.
                if (fall) begin
`ifdef BTN_DOUBLE_EN
                    state_d = GAP;
`else
                    short_d = 1'b1;
                    state_d = IDLE;
`endif
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = WAIT_REL;
                end
            end
`ifdef BTN_DOUBLE_EN
            GAP: begin
                // The level is low throughout GAP, so any high sample is a rise.
                if (rise) begin
                    dbl_d   = 1'b1;
                    state_d = WAIT_REL;
                end else if (cnt_q == GAP_LAST) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            WAIT_REL: begin
                if (fall) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != IDLE && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            btn_dly_q <= 1'b1;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            dbl_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            btn_dly_q <= btn_dly_d;
            short_q   <= short_d;
            long_q    <= long_d;
            dbl_q     <= dbl_d;
        end
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_click = dbl_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_btn_press_decoder.sv
// ---------------------------------------------------------------------------
// tb_btn_press_decoder
//
// Self-checking bench for btn_press_decoder with LONG_CNT=20, DOUBLE_GAP=10.
// Expectations follow whichever build is compiled (BTN_DOUBLE_EN defined or
// not). A timestamp-based gesture model runs alongside every sampled edge.
// ---------------------------------------------------------------------------
module tb_btn_press_decoder;

    localparam int LONG = 20;
    localparam int GAPN = 10;
`ifdef BTN_DOUBLE_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic clk;
    logic reset;
    logic btn_stable;
    logic short_press;
    logic long_press;
    logic double_click;
    logic busy;

    btn_press_decoder #(
        .LONG_CNT  (LONG),
        .DOUBLE_GAP(GAPN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_stable  (btn_stable),
        .short_press (short_press),
        .long_press  (long_press),
        .double_click(double_click),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int edge_n = 0;

    int n_short, n_long, n_dbl;
    int short_edges[$];
    int long_edges[$];
    int dbl_edges[$];

    // Gesture model: remembers when the current press started / the first
    // press was released, and whether the rest of a press is being ignored.
    int m_prev, press_t, rel_t;
    bit ignore_rel;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic void model_reset();
        m_prev     = 1;
        press_t    = -1;
        rel_t      = -1;
        ignore_rel = 1'b0;
    endfunction

    function automatic void model_edge(input int n, input int b,
                                       output bit es, output bit el, output bit ed);
        es = 1'b0; el = 1'b0; ed = 1'b0;
        if (ignore_rel) begin
            if (b == 0) ignore_rel = 1'b0;
        end else if (press_t >= 0) begin
            if (b == 0) begin
                press_t = -1;
                if (DBL) rel_t = n;
                else es = 1'b1;
            end else if (n - press_t == LONG) begin
                el = 1'b1;
                press_t = -1;
                ignore_rel = 1'b1;
            end
        end else if (rel_t >= 0) begin
            if (b == 1) begin
                ed = 1'b1;
                rel_t = -1;
                ignore_rel = 1'b1;
            end else if (n - rel_t == GAPN) begin
                es = 1'b1;
                rel_t = -1;
            end
        end else if (b == 1 && m_prev == 0) begin
            press_t = n;
        end
        m_prev = b;
    endfunction

    function automatic void clear_log();
        n_short = 0; n_long = 0; n_dbl = 0;
        short_edges.delete();
        long_edges.delete();
        dbl_edges.delete();
    endfunction

    // One sampled edge: drive the level, clock, compare against the model.
    task automatic step(input logic b);
        bit es, el, ed, eb;
        btn_stable = b;
        @(posedge clk);
        edge_n++;
        model_edge(edge_n, int'(b), es, el, ed);
        eb = (press_t >= 0) || (rel_t >= 0) || ignore_rel;
        #1;
        chk("model{short,long,dbl,busy}",
            int'({short_press, long_press, double_click, busy}),
            int'({es, el, ed, eb}));
        if (short_press)  begin n_short++; short_edges.push_back(edge_n); end
        if (long_press)   begin n_long++;  long_edges.push_back(edge_n);  end
        if (double_click) begin n_dbl++;   dbl_edges.push_back(edge_n);   end
    endtask

    task automatic run(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    task automatic do_reset(input logic b);
        btn_stable = b;
        #2;
        reset = 1'b1;
        #1;
        chk("reset_async_outs", int'({short_press, long_press, double_click, busy}), 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        int hi1, lo1, hi2, lo2;
        int s_d, l_d, d_d;   // expected counts, BTN_DOUBLE_EN defined
        int s_n, l_n, d_n;   // expected counts, BTN_DOUBLE_EN undefined
    } vec_t;

    vec_t vecs[11];

    int k, f, f1, f2, r2;

    initial begin
        reset      = 1'b1;
        btn_stable = 1'b0;
        model_reset();
        clear_log();

        vecs[0]  = '{5,  15, 0,  0,  1, 0, 0,  1, 0, 0};
        vecs[1]  = '{30, 15, 0,  0,  0, 1, 0,  0, 1, 0};
        vecs[2]  = '{4,  6,  4,  15, 0, 0, 1,  2, 0, 0};
        vecs[3]  = '{20, 15, 0,  0,  1, 0, 0,  1, 0, 0};
        vecs[4]  = '{5,  10, 5,  15, 0, 0, 1,  2, 0, 0};
        vecs[5]  = '{5,  11, 5,  15, 2, 0, 0,  2, 0, 0};
        vecs[6]  = '{5,  6,  30, 15, 0, 0, 1,  1, 1, 0};
        vecs[7]  = '{25, 3,  5,  15, 1, 1, 0,  1, 1, 0};
        vecs[8]  = '{1,  15, 0,  0,  1, 0, 0,  1, 0, 0};
        vecs[9]  = '{19, 15, 0,  0,  1, 0, 0,  1, 0, 0};
        vecs[10] = '{21, 15, 0,  0,  0, 1, 0,  0, 1, 0};

        // Reset values
        repeat (2) @(posedge clk);
        #2;
        chk("rst_short", int'(short_press), 0);
        chk("rst_long",  int'(long_press), 0);
        chk("rst_dbl",   int'(double_click), 0);
        chk("rst_busy",  int'(busy), 0);
        reset = 1'b0;
        model_reset();

        run(1'b0, 3);

        // Table of gestures: pulse counts per build, idle afterwards
        for (int v = 0; v < 11; v++) begin
            clear_log();
            run(1'b1, vecs[v].hi1);
            run(1'b0, vecs[v].lo1);
            if (vecs[v].hi2 > 0) run(1'b1, vecs[v].hi2);
            run(1'b0, vecs[v].lo2 + 15);
            chk($sformatf("vec%0d_short", v), n_short, DBL ? vecs[v].s_d : vecs[v].s_n);
            chk($sformatf("vec%0d_long",  v), n_long,  DBL ? vecs[v].l_d : vecs[v].l_n);
            chk($sformatf("vec%0d_dbl",   v), n_dbl,   DBL ? vecs[v].d_d : vecs[v].d_n);
            chk($sformatf("vec%0d_idle",  v), int'(busy), 0);
        end

        // Short press timing
        clear_log();
        run(1'b1, 5);
        f = edge_n + 1;
        run(1'b0, 15);
        chk("short_count", n_short, 1);
        chk("short_edge", (n_short > 0) ? short_edges[0] : -1, DBL ? f + GAPN : f);

        // Long press timing and release
        clear_log();
        k = edge_n + 1;
        run(1'b1, 30);
        f = edge_n + 1;
        step(1'b0);
        chk("long_release_busy", int'(busy), 0);
        run(1'b0, 15);
        chk("long_count", n_long, 1);
        chk("long_edge", (n_long > 0) ? long_edges[0] : -1, k + LONG);
        chk("long_no_short", n_short, 0);

        // Double-click (or two shorts without the gap state)
        clear_log();
        run(1'b1, 4);
        f1 = edge_n + 1;
        run(1'b0, 6);
        r2 = edge_n + 1;
        run(1'b1, 4);
        f2 = edge_n + 1;
        run(1'b0, 15);
        if (DBL) begin
            chk("dbl_count", n_dbl, 1);
            chk("dbl_edge", (n_dbl > 0) ? dbl_edges[0] : -1, r2);
            chk("dbl_no_short", n_short, 0);
        end else begin
            chk("two_short_count", n_short, 2);
            chk("two_short_edge0", (n_short > 0) ? short_edges[0] : -1, f1);
            chk("two_short_edge1", (n_short > 1) ? short_edges[1] : -1, f2);
            chk("no_dbl", n_dbl, 0);
        end

        // Button held through reset release
        do_reset(1'b1);
        clear_log();
        run(1'b1, 40);
        chk("held_busy", int'(busy), 0);
        run(1'b0, 15);
        chk("held_pulses", n_short + n_long + n_dbl, 0);

        // Reset asserted mid-gap
        clear_log();
        run(1'b1, 5);
        run(1'b0, 3);
        chk("gap_busy_before_reset", int'(busy), DBL ? 1 : 0);
        do_reset(1'b0);
        clear_log();
        run(1'b0, 20);
        chk("gap_reset_no_short", n_short, 0);

        // Randomised level runs, with occasional resets
        for (int g = 0; g < 60; g++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end
            run(1'(g % 2 == 0), $urandom_range(1, 32));
        end
        run(1'b0, 40);
        chk("final_idle", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
